// File: rtl/sr595_loader.sv
// sr595_loader: serial frame generator for a 74595-class shift/latch register
// (or a daisy chain of them). Accepts a parallel word on a valid/ready
// handshake, shifts it out MSB-first on ser/srclk, pulses rclk to latch it,
// then holds oe_n low.
//
// Optional feature macro: SR595_CLEAR_EN
//   When defined, adds the clr_req input and srclr_n output and a CLEAR state
//   that wipes the device shift stage and latches the zeros.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a frame (or a clear request); ready_out high
// SHIFT_LO | ser presents the current MSB, srclk low, DIV cycles
// SHIFT_HI | srclk high, ser held, DIV cycles; shift register advances at exit
// LATCH    | rclk high for DIV cycles; oe_n drops at exit
// CLEAR    | srclr_n low for DIV cycles (SR595_CLEAR_EN only)
//
// Pin outputs are registered from the current state, so every pin lags the
// state register by one cycle. This gives the first srclk rise DIV+1 cycles
// after accept and puts the rclk rise on the same edge as the last srclk fall.

module sr595_loader #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             oe_n,
`ifdef SR595_CLEAR_EN
  output logic             srclr_n,
  input  logic             clr_req,
`endif
  output logic             busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PH_LOAD  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
`ifdef SR595_CLEAR_EN
    CLEAR    = 3'd4,
`endif
    LATCH    = 3'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic             armed;
  logic             phase_done;
  logic             bit_last;
  logic             clr_go;
  logic             accept;
  logic             ser_d;
  logic             srclk_d;
  logic             rclk_d;
  logic             oe_n_d;
`ifdef SR595_CLEAR_EN
  logic             srclr_n_d;
`endif

`ifdef SR595_CLEAR_EN
  assign clr_go = clr_req;
`else
  assign clr_go = 1'b0;
`endif

  // armed keeps ready_out low until the first edge after reset release
  assign phase_done = (phase == '0);
  assign bit_last   = (bitcnt == '0);
  assign ready_out  = (state == IDLE) && armed && !clr_go;
  assign busy       = (state != IDLE);
  assign accept     = valid_in && ready_out;

  // state register plus phase/bit down-counters and the frame shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      armed  <= 1'b0;
      phase  <= PH_LOAD;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if ((state != IDLE) && !phase_done)
        phase <= phase - PW'(1);
      else
        phase <= PH_LOAD;
      if (accept) begin
        shreg  <= data_in;
        bitcnt <= BIT_LOAD;
      end else if ((state == SHIFT_HI) && phase_done) begin
        shreg <= shreg << 1;
        if (!bit_last)
          bitcnt <= bitcnt - BW'(1);
      end
    end
  end

  // next-state decode; a phase ends when the down-counter reaches zero
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = SHIFT_LO;
`ifdef SR595_CLEAR_EN
        if (clr_req && armed)
          state_nxt = CLEAR;
`endif
      end
      SHIFT_LO: if (phase_done) state_nxt = SHIFT_HI;
      SHIFT_HI: if (phase_done) state_nxt = bit_last ? LATCH : SHIFT_LO;
      LATCH:    if (phase_done) state_nxt = IDLE;
`ifdef SR595_CLEAR_EN
      CLEAR:    if (phase_done) state_nxt = LATCH;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  // pin values for the next cycle, derived from the current state
  always_comb begin
    ser_d   = ser;
    srclk_d = 1'b0;
    rclk_d  = 1'b0;
    oe_n_d  = oe_n;
`ifdef SR595_CLEAR_EN
    srclr_n_d = 1'b1;
`endif
    case (state)
      SHIFT_LO: ser_d = shreg[WIDTH-1];
      SHIFT_HI: srclk_d = 1'b1;
      LATCH: begin
        rclk_d = 1'b1;
        if (phase_done)
          oe_n_d = 1'b0;
      end
`ifdef SR595_CLEAR_EN
      CLEAR: srclr_n_d = 1'b0;
`endif
      default: ;
    endcase
  end

  // registered pins so the device never sees decode glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser   <= 1'b0;
      srclk <= 1'b0;
      rclk  <= 1'b0;
      oe_n  <= 1'b1;
`ifdef SR595_CLEAR_EN
      srclr_n <= 1'b1;
`endif
    end else begin
      ser   <= ser_d;
      srclk <= srclk_d;
      rclk  <= rclk_d;
      oe_n  <= oe_n_d;
`ifdef SR595_CLEAR_EN
      srclr_n <= srclr_n_d;
`endif
    end
  end

endmodule

// File: tb/tb_sr595_loader.sv
// Directed bench for sr595_loader with behavioural 74595 models attached.
// dut1: WIDTH=8 DIV=2 driving one device; dut2: WIDTH=16 DIV=1 driving two
// chained devices. The clear scenario is built only with SR595_CLEAR_EN.
`timescale 1ns/1ps
module tb_sr595_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  logic [7:0]  d1_data = '0;
  logic        d1_valid = 1'b0;
  logic        d1_ready, d1_ser, d1_srclk, d1_rclk, d1_oe_n, d1_busy;
  logic [15:0] d2_data = '0;
  logic        d2_valid = 1'b0;
  logic        d2_ready, d2_ser, d2_srclk, d2_rclk, d2_oe_n, d2_busy;
`ifdef SR595_CLEAR_EN
  logic        d1_clr = 1'b0;
  logic        d1_srclr_n, d2_srclr_n;
`endif

  sr595_loader #(.WIDTH(8), .DIV(2)) dut1 (
    .clk(clk), .reset(reset), .data_in(d1_data), .valid_in(d1_valid),
    .ready_out(d1_ready), .ser(d1_ser), .srclk(d1_srclk), .rclk(d1_rclk),
    .oe_n(d1_oe_n),
`ifdef SR595_CLEAR_EN
    .srclr_n(d1_srclr_n), .clr_req(d1_clr),
`endif
    .busy(d1_busy)
  );

  sr595_loader #(.WIDTH(16), .DIV(1)) dut2 (
    .clk(clk), .reset(reset), .data_in(d2_data), .valid_in(d2_valid),
    .ready_out(d2_ready), .ser(d2_ser), .srclk(d2_srclk), .rclk(d2_rclk),
    .oe_n(d2_oe_n),
`ifdef SR595_CLEAR_EN
    .srclr_n(d2_srclr_n), .clr_req(1'b0),
`endif
    .busy(d2_busy)
  );

  // device model for dut1
  logic        dev1_srclr_n;
  logic [7:0]  dev1_sh = '0;
  logic [7:0]  dev1_q = '0;
  logic [15:0] d1_cap = '0;
  int          d1_srise = 0;
  int          d1_rrise = 0;
`ifdef SR595_CLEAR_EN
  assign dev1_srclr_n = d1_srclr_n;
`else
  assign dev1_srclr_n = 1'b1;
`endif

  always @(posedge d1_srclk or negedge dev1_srclr_n) begin
    if (!dev1_srclr_n) begin
      dev1_sh <= '0;
    end else begin
      dev1_sh  <= {dev1_sh[6:0], d1_ser};
      d1_cap   <= {d1_cap[14:0], d1_ser};
      d1_srise <= d1_srise + 1;
    end
  end

  always @(posedge d1_rclk) begin
    dev1_q   <= dev1_sh;
    d1_rrise <= d1_rrise + 1;
  end

  // two chained devices for dut2: upper byte is the far device
  logic [15:0] dev2_sh = '0;
  logic [15:0] dev2_q = '0;
  always @(posedge d2_srclk) dev2_sh <= {dev2_sh[14:0], d2_ser};
  always @(posedge d2_rclk)  dev2_q  <= dev2_sh;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] v, output int n);
    d1_data  = v;
    d1_valid = 1'b1;
    tick();
    d1_valid = 1'b0;
    n = 0;
    while (!d1_ready && n < 300) begin
      tick();
      n++;
    end
    chk("frame_done", d1_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=done");
    $fatal(1);
  end

  initial begin
    int n, s0, r0, rhigh, first_sr;
    logic oe33;

    // reset values
    repeat (2) tick();
    chk("rst_ready", d1_ready, 0);
    chk("rst_ser", d1_ser, 0);
    chk("rst_srclk", d1_srclk, 0);
    chk("rst_rclk", d1_rclk, 0);
    chk("rst_oe_n", d1_oe_n, 1);
    chk("rst_busy", d1_busy, 0);
    reset = 1'b0;
    chk("rel_ready_before_edge", d1_ready, 0);
    tick();
    chk("rel_ready_after_edge", d1_ready, 1);

    // single frame 8'hA5
    s0 = d1_srise; r0 = d1_rrise;
    d1_data = 8'hA5; d1_valid = 1'b1;
    tick();
    d1_valid = 1'b0;
    chk("a5_busy", d1_busy, 1);
    n = 0; rhigh = 0; oe33 = 1'bx; first_sr = -1;
    while (!d1_ready && n < 200) begin
      tick();
      n++;
      if (d1_rclk) rhigh++;
      if (d1_srclk && first_sr < 0) first_sr = n;
      if (n == 33) oe33 = d1_oe_n;
    end
    chk("a5_ready_cycles", n, 34);
    chk("a5_first_srclk", first_sr, 3);
    chk("a5_oe_n_at33", oe33, 1);
    chk("a5_oe_n_at34", d1_oe_n, 0);
    repeat (2) begin
      tick();
      if (d1_rclk) rhigh++;
    end
    chk("a5_srclk_rises", d1_srise - s0, 8);
    chk("a5_ser_bits", d1_cap[7:0], 8'hA5);
    chk("a5_rclk_pulses", d1_rrise - r0, 1);
    chk("a5_rclk_width", rhigh, 2);
    chk("a5_dev_q", dev1_q, 8'hA5);

    // back-to-back FF then 00 with valid held high
    d1_data = 8'hFF; d1_valid = 1'b1;
    tick();
    d1_data = 8'h00;
    n = 0;
    while (!d1_ready && n < 200) begin
      tick();
      n++;
      if (n == 10) d1_data = 8'h5A;
      if (n == 20) d1_data = 8'h00;
    end
    chk("b2b_ff_cycles", n, 34);
    chk("b2b_ff_q", dev1_q, 8'hFF);
    chk("b2b_ff_bits", d1_cap[7:0], 8'hFF);
    tick();
    chk("b2b_second_accept_ready", d1_ready, 0);
    chk("b2b_second_accept_busy", d1_busy, 1);
    d1_valid = 1'b0;
    n = 0;
    while (!d1_ready && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_00_cycles", n, 34);
    chk("b2b_00_q", dev1_q, 8'h00);
    chk("b2b_00_bits", d1_cap[7:0], 8'h00);

    // reset after three srclk rises of 8'h3C
    d1_data = 8'h3C; d1_valid = 1'b1;
    tick();
    d1_valid = 1'b0;
    s0 = d1_srise; r0 = d1_rrise;
    n = 0;
    while ((d1_srise - s0) < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_srclk_high", d1_srclk, 1);
    chk("mid_ser_third_bit", d1_ser, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ser", d1_ser, 0);
    chk("mid_rst_srclk", d1_srclk, 0);
    chk("mid_rst_rclk", d1_rclk, 0);
    chk("mid_rst_oe_n", d1_oe_n, 1);
    chk("mid_rst_busy", d1_busy, 0);
    chk("mid_rst_ready", d1_ready, 0);
    repeat (3) tick();
    chk("mid_rst_no_rclk", d1_rrise - r0, 0);
    chk("mid_rst_q_kept", dev1_q, 8'h00);
    reset = 1'b0;
    chk("mid_rel_ready_low", d1_ready, 0);
    tick();
    chk("mid_rel_ready_high", d1_ready, 1);
    run_frame(8'h81, n);
    chk("post_rst_cycles", n, 34);
    chk("post_rst_q", dev1_q, 8'h81);

    // 16-bit frame into two chained devices, DIV=1
    d2_data = 16'h1234; d2_valid = 1'b1;
    tick();
    d2_valid = 1'b0;
    n = 0;
    while (!d2_ready && n < 200) begin
      tick();
      n++;
    end
    chk("w16_busy_cycles", n, 33);
    tick();
    chk("w16_far", dev2_q[15:8], 8'h12);
    chk("w16_near", dev2_q[7:0], 8'h34);

`ifdef SR595_CLEAR_EN
    // clear wins over a simultaneous frame
    run_frame(8'hA5, n);
    tick();
    chk("clr_pre_q", dev1_q, 8'hA5);
    s0 = d1_srise; r0 = d1_rrise;
    d1_clr = 1'b1; d1_data = 8'h77; d1_valid = 1'b1;
    #1;
    chk("clr_ready_masked", d1_ready, 0);
    tick();
    d1_clr = 1'b0; d1_valid = 1'b0;
    begin
      int lo, rdy;
      lo = 0; rdy = 0;
      for (int i = 0; i < 6; i++) begin
        if (i < 3 && d1_ready) rdy++;
        if (!d1_srclr_n) lo++;
        tick();
      end
      chk("clr_srclr_low_cycles", lo, 2);
      chk("clr_ready_during", rdy, 0);
    end
    chk("clr_rclk_pulse", d1_rrise - r0, 1);
    chk("clr_no_shift", d1_srise - s0, 0);
    chk("clr_q", dev1_q, 8'h00);
    chk("clr_oe_n", d1_oe_n, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
